// File: rtl/dcache_pkg.sv
// Shared encodings and the width helper for the set-associative data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    OP_READ       = 2'b00,
    OP_WRITE      = 2'b01,
    OP_FILL_CLEAN = 2'b10,
    OP_FILL_DIRTY = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_WB   = 2'b10
  } flush_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      r = ((32'sd1 <<< i) < n) ? (i + 1) : r;
    end
    return r;
  endfunction

endpackage

// File: rtl/dcache_lru.sv
// Age-based LRU helper for one set: age update on a touch and victim selection.
module dcache_lru #(
  parameter int WAYS  = 2,
  parameter int WAY_W = 1
) (
  input  logic [WAYS*WAY_W-1:0] age_i,
  input  logic [WAYS-1:0]       valid_i,
  input  logic [WAY_W-1:0]      touch_way_i,
  output logic [WAYS*WAY_W-1:0] age_o,
  output logic [WAY_W-1:0]      victim_o
);

  logic [WAY_W-1:0] touched_age_s;
  logic             free_found_s;

  // Ways younger than the touched one age by one; the touched way becomes youngest.
  always_comb begin
    touched_age_s = '0;
    age_o         = age_i;
    for (int w = 0; w < WAYS; w++) begin
      touched_age_s = (WAY_W'(w) == touch_way_i) ? age_i[w*WAY_W +: WAY_W] : touched_age_s;
    end
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == touch_way_i) begin
        age_o[w*WAY_W +: WAY_W] = '0;
      end else if (age_i[w*WAY_W +: WAY_W] < touched_age_s) begin
        age_o[w*WAY_W +: WAY_W] = age_i[w*WAY_W +: WAY_W] + WAY_W'(1);
      end else begin
        age_o[w*WAY_W +: WAY_W] = age_i[w*WAY_W +: WAY_W];
      end
    end
  end

  // Victim: lowest-index free way, otherwise the oldest way.
  always_comb begin
    victim_o     = '0;
    free_found_s = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!valid_i[w] && !free_found_s) begin
        victim_o     = WAY_W'(w);
        free_found_s = 1'b1;
      end else begin
        free_found_s = free_found_s;
      end
    end
    if (!free_found_s) begin
      for (int w = 0; w < WAYS; w++) begin
        victim_o = (age_i[w*WAY_W +: WAY_W] == WAY_W'(WAYS-1)) ? WAY_W'(w) : victim_o;
      end
    end else begin
      victim_o = victim_o;
    end
  end

endmodule

// File: rtl/dcache_sram_assoc.sv
// Set-associative data cache array with LRU replacement and a line-by-line
// flush engine that writes dirty lines back before invalidating them.
module dcache_sram_assoc
  import dcache_pkg::*;
#(
  parameter int SETS   = 16,
  parameter int WAYS   = 2,
  parameter int TAG_W  = 23,
  parameter int LINE_W = 256,
  localparam int IDX_W = clog2(SETS),
  localparam int WAY_W = (WAYS > 1) ? clog2(WAYS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic [1:0]        op_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              hit_o,
  output logic [LINE_W-1:0] data_o,
  output logic [WAY_W-1:0]  way_o,
  output logic              victim_valid_o,
  output logic              victim_dirty_o,
  output logic [TAG_W-1:0]  victim_tag_o,
  output logic [LINE_W-1:0] victim_data_o,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [IDX_W-1:0]  wb_idx_o,
  output logic [TAG_W-1:0]  wb_tag_o,
  output logic [LINE_W-1:0] wb_data_o
);

  logic              valid_q [SETS][WAYS];
  logic              dirty_q [SETS][WAYS];
  logic [WAY_W-1:0]  age_q   [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];

  flush_state_e     state_q, state_d;
  logic [IDX_W-1:0] cur_set_q, cur_set_d;
  logic [WAY_W-1:0] cur_way_q, cur_way_d;
  logic             line_clear_s, age_init_s, advance_s, last_s, busy_s;

  logic                   found_s, acc_s, fill_s, write_s, touch_s;
  logic [WAY_W-1:0]       hit_way_s, vic_way_s, tgt_way_s;
  logic [WAYS-1:0]        set_valid_s;
  logic [WAYS*WAY_W-1:0]  set_age_s, new_age_s;

  // Tag compare across the indexed set; the lowest matching way wins.
  always_comb begin
    found_s     = 1'b0;
    hit_way_s   = '0;
    set_valid_s = '0;
    set_age_s   = '0;
    for (int w = 0; w < WAYS; w++) begin
      set_valid_s[w]              = valid_q[idx_i][w];
      set_age_s[w*WAY_W +: WAY_W] = age_q[idx_i][w];
      if (valid_q[idx_i][w] && (tag_q[idx_i][w] == tag_i) && !found_s) begin
        found_s   = 1'b1;
        hit_way_s = WAY_W'(w);
      end else begin
        found_s = found_s;
      end
    end
  end

  assign busy_s    = (state_q != ST_IDLE);
  assign acc_s     = req_i && !busy_s;
  assign fill_s    = acc_s && op_i[1];
  assign write_s   = acc_s && (op_i == OP_WRITE) && found_s;
  assign touch_s   = fill_s || (acc_s && found_s);
  assign tgt_way_s = (fill_s && !found_s) ? vic_way_s : hit_way_s;
  assign last_s    = (cur_set_q == IDX_W'(SETS-1)) && (cur_way_q == WAY_W'(WAYS-1));

  dcache_lru #(.WAYS(WAYS), .WAY_W(WAY_W)) u_lru (
    .age_i       (set_age_s),
    .valid_i     (set_valid_s),
    .touch_way_i (tgt_way_s),
    .age_o       (new_age_s),
    .victim_o    (vic_way_s)
  );

  // Lookup and replacement outputs, suppressed while a flush owns the array.
  always_comb begin
    hit_o          = 1'b0;
    way_o          = '0;
    data_o         = '0;
    victim_valid_o = 1'b0;
    victim_dirty_o = 1'b0;
    victim_tag_o   = '0;
    victim_data_o  = '0;
    if (!busy_s && found_s) begin
      hit_o  = 1'b1;
      way_o  = hit_way_s;
      data_o = data_q[idx_i][hit_way_s];
    end else begin
      hit_o = 1'b0;
    end
    if (!busy_s && valid_q[idx_i][vic_way_s]) begin
      victim_valid_o = 1'b1;
      victim_dirty_o = dirty_q[idx_i][vic_way_s];
      victim_tag_o   = tag_q[idx_i][vic_way_s];
      victim_data_o  = data_q[idx_i][vic_way_s];
    end else begin
      victim_valid_o = 1'b0;
    end
  end

  assign busy_o     = busy_s;
  assign wb_valid_o = (state_q == ST_WB);
  assign wb_idx_o   = cur_set_q;
  assign wb_tag_o   = wb_valid_o ? tag_q[cur_set_q][cur_way_q] : '0;
  assign wb_data_o  = wb_valid_o ? data_q[cur_set_q][cur_way_q] : '0;

  // Flush sequencing: cursor walks ways first, then sets; dirty lines detour via WB.
  always_comb begin
    state_d      = state_q;
    cur_set_d    = cur_set_q;
    cur_way_d    = cur_way_q;
    line_clear_s = 1'b0;
    advance_s    = 1'b0;
    age_init_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush_i) begin
          state_d   = ST_SCAN;
          cur_set_d = '0;
          cur_way_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (valid_q[cur_set_q][cur_way_q] && dirty_q[cur_set_q][cur_way_q]) begin
          state_d = ST_WB;
        end else begin
          line_clear_s = 1'b1;
          advance_s    = 1'b1;
        end
      end
      ST_WB: begin
        if (wb_ready_i) begin
          line_clear_s = 1'b1;
          advance_s    = 1'b1;
        end else begin
          state_d = ST_WB;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (advance_s) begin
      state_d = ST_SCAN;
      if (last_s) begin
        state_d    = ST_IDLE;
        cur_set_d  = '0;
        cur_way_d  = '0;
        age_init_s = 1'b1;
      end else if (cur_way_q == WAY_W'(WAYS-1)) begin
        cur_way_d = '0;
        cur_set_d = cur_set_q + IDX_W'(1);
      end else begin
        cur_way_d = cur_way_q + WAY_W'(1);
      end
    end else begin
      age_init_s = 1'b0;
    end
  end

  // Flush state and cursor registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cur_set_q <= '0;
      cur_way_q <= '0;
    end else begin
      state_q   <= state_d;
      cur_set_q <= cur_set_d;
      cur_way_q <= cur_way_d;
    end
  end

  // Valid, dirty and age state; access updates and flush clears never coincide.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          age_q[s][w]   <= WAY_W'(w);
        end
      end
    end else begin
      if (touch_s) begin
        for (int w = 0; w < WAYS; w++) begin
          age_q[idx_i][w] <= new_age_s[w*WAY_W +: WAY_W];
        end
      end
      if (fill_s) begin
        valid_q[idx_i][tgt_way_s] <= 1'b1;
        dirty_q[idx_i][tgt_way_s] <= op_i[0] | (found_s & dirty_q[idx_i][tgt_way_s]);
      end
      if (write_s) begin
        dirty_q[idx_i][tgt_way_s] <= 1'b1;
      end
      if (line_clear_s) begin
        valid_q[cur_set_q][cur_way_q] <= 1'b0;
        dirty_q[cur_set_q][cur_way_q] <= 1'b0;
      end
      if (age_init_s) begin
        for (int s = 0; s < SETS; s++) begin
          for (int w = 0; w < WAYS; w++) begin
            age_q[s][w] <= WAY_W'(w);
          end
        end
      end
    end
  end

  // Tag and line storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk_i) begin
    if (fill_s) begin
      tag_q[idx_i][tgt_way_s] <= tag_i;
    end
    if (fill_s || write_s) begin
      data_q[idx_i][tgt_way_s] <= data_i;
    end
  end

endmodule

// File: doc/dcache_sram_assoc.md
DCACHE_SRAM_ASSOC -- requirements
Module: dcache_sram_assoc

Interface
REQ-001 Parameter SETS, 16, number of sets; power of 2, 2..256.
REQ-002 Parameter WAYS, 2, associativity; power of 2, 1..8.
REQ-003 Parameter TAG_W, 23, tag width.
REQ-004 Parameter LINE_W, 256, cache line width in bits.
REQ-005 Derived: IDX_W = clog2(SETS); WAY_W = max(1, clog2(WAYS)).
REQ-006 clk_i  in  1  clock; all state updates occur on its rising edge.
REQ-007 rst_i  in  1  reset, asynchronous, active-high.
REQ-008 req_i  in  1  access valid this cycle.
REQ-009 op_i  in  2  operation: 00 read, 01 write-hit, 10 fill clean, 11 fill dirty.
REQ-010 idx_i  in  IDX_W  set index.
REQ-011 tag_i  in  TAG_W  lookup/fill tag.
REQ-012 data_i  in  LINE_W  write/fill line.
REQ-013 hit_o  out  1; data_o  out  LINE_W; way_o  out  WAY_W: combinational lookup result for idx_i/tag_i.
REQ-014 victim_valid_o, victim_dirty_o  out  1; victim_tag_o  out  TAG_W; victim_data_o  out  LINE_W: combinational replacement candidate for idx_i.
REQ-015 flush_i  in  1  pulse requesting write-back and invalidation of all lines.
REQ-016 busy_o  out  1  flush in progress.
REQ-017 wb_valid_o  out  1; wb_ready_i  in  1; wb_idx_o  out  IDX_W; wb_tag_o  out  TAG_W; wb_data_o  out  LINE_W: flush write-back channel.

Function
REQ-018 Hit in a way when that way is valid and its tag equals tag_i; hit_o = any hit; way_o = lowest hitting way index, else 0; data_o = that way's data, else 0.
REQ-019 LRU: per-set age counters of WAY_W bits, forming a permutation of 0..WAYS-1; age 0 = most recently used.
REQ-020 On an LRU touch of way w: every way with age < age[w] increments; age[w] becomes 0; other ages unchanged.
REQ-021 Victim = lowest-index invalid way; if none, the way with age WAYS-1; victim_tag_o/victim_data_o are 0 when victim_valid_o = 0.
REQ-022 Read (00) hit: touch hit way; miss: no state change.
REQ-023 Write-hit (01) hit: write data_i to hit way, set dirty, touch; miss: no state change.
REQ-024 Fill (10/11) on miss: victim way gets tag_i, data_i, valid = 1, dirty = op_i[0]; touch.
REQ-025 Fill on hit: overwrite the hit way in place (no duplicate tag); dirty = op_i[0] OR old dirty; touch.
REQ-026 All updates occur at the edge following the request cycle; combinational outputs reflect updated state the next cycle.
REQ-027 Flush FSM states IDLE, SCAN, WB: IDLE->SCAN on flush_i, cursor (set 0, way 0).
REQ-028 SCAN: one line per cycle; if valid and dirty -> WB; otherwise clear valid, advance cursor way-first then set.
REQ-029 WB: wb_valid_o = 1 with cursor set/tag/data, held stable until wb_ready_i; on handshake clear valid and dirty, advance, return to SCAN.
REQ-030 After the last line (set SETS-1, way WAYS-1) -> IDLE; ages are re-initialised to the reset permutation.
REQ-031 busy_o = 1 in SCAN and WB; while busy, req_i is ignored and hit_o, victim_valid_o are forced to 0; flush_i while busy is ignored.
REQ-032 flush_i and req_i in the same IDLE cycle: the access is performed, then the flush starts.

Reset
REQ-033 rst_i clears all valid and dirty bits, sets age[way] = way for every set, and places the FSM in IDLE with cursor 0.
REQ-034 Tag/data arrays need not be reset; all outputs are 0 during and after reset until a fill occurs.
REQ-035 Reset mid-flush aborts immediately; no further wb_valid_o is issued.

Structure
REQ-036 Package dcache_pkg holds op_i encodings, flush FSM state enum, and the clog2 helper.
REQ-037 Sub-module dcache_lru (one per design, indexed by set) computes the age update and victim selection for a WAYS-wide age vector.

Verification (SETS=16, WAYS=4)
REQ-038 After reset, read idx 3 tag 0x12 -> hit_o = 0, data_o = 0, victim_valid_o = 0.
REQ-039 Fill idx 3 tags 0xA, 0xB, 0xC, 0xD (clean), then fill 0xE -> 0xA is replaced; lookup 0xA misses, 0xE hits.
REQ-040 Fill 0xA-0xD, read 0xA, fill 0xE -> 0xB is evicted; 0xA still hits.
REQ-041 Write-hit 0xB with data 0x55..55, then present idx 3 when 0xB is LRU -> victim_dirty_o = 1, victim_data_o = 0x55..55.
REQ-042 Two dirty lines (idx 2 way 1, idx 9 way 0), flush, wb_ready_i low 3 cycles -> wb outputs stable, exactly 2 handshakes in index order, busy_o = 64 + 2 + 3 cycles, then all lookups miss.
REQ-043 Assert rst_i during WB of a flush -> busy_o = 0, wb_valid_o = 0, all lines invalid next cycle.
